// File: rtl/soc_pio_pkg.sv
// soc_pio_pkg: register map and mode encodings shared by the PIO slave
package soc_pio_pkg;
    localparam logic [2:0] ADDR_DATA = 3'd0;
    localparam logic [2:0] ADDR_MASK = 3'd2;
    localparam logic [2:0] ADDR_EDGE = 3'd3;
    localparam logic [2:0] ADDR_SET  = 3'd4;
    localparam logic [2:0] ADDR_CLR  = 3'd5;
    typedef enum int {EDGE_RISING = 0, EDGE_FALLING = 1, EDGE_ANY = 2} edge_e;
    typedef enum int {IRQ_LEVEL = 0, IRQ_EDGE = 1} irq_mode_e;
endpackage

// File: rtl/pio_sync_edge.sv
// pio_sync_edge: multi-stage input synchroniser with one cycle of history for edge events
module pio_sync_edge
    import soc_pio_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] in_sync,
    output logic [WIDTH-1:0] edge_evt
);
    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] prev_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            prev_q <= '0;
        end else begin
            sync_q[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end
    assign in_sync  = sync_q[SYNC_STAGES-1];
    assign edge_evt = EDGE_TYPE == EDGE_RISING  ? in_sync & ~prev_q :
                      EDGE_TYPE == EDGE_FALLING ? ~in_sync & prev_q : in_sync ^ prev_q;
endmodule

// File: rtl/soc_system_pio_gen.sv
// soc_system_pio_gen: Avalon-MM PIO slave with set/clear output register,
// synchronised edge-capturing input port and a maskable interrupt
module soc_system_pio_gen
    import soc_pio_pkg::*;
#(
    parameter int               WIDTH       = 16,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int               SYNC_STAGES = 2,
    parameter int               EDGE_TYPE   = 0,
    parameter int               IRQ_MODE    = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic             irq
);
    logic             wr;
    logic             unused_wd;
    logic [WIDTH-1:0] wdata, in_sync, edge_evt;
    logic [WIDTH-1:0] data_q, data_d, mask_q, mask_d, cap_q, cap_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             irq_q, irq_d;

    assign wr        = chipselect & ~write_n;
    assign wdata     = writedata[WIDTH-1:0];
    assign unused_wd = ^writedata;

    pio_sync_edge #(
        .WIDTH      (WIDTH),
        .SYNC_STAGES(SYNC_STAGES),
        .EDGE_TYPE  (EDGE_TYPE)
    ) u_sync (
        .clk     (clk),
        .reset   (reset),
        .in_port (in_port),
        .in_sync (in_sync),
        .edge_evt(edge_evt)
    );

    // A new event is ORed in after the clear so it survives a same-cycle clear
    always_comb begin
        data_d  = !wr                   ? data_q :
                  address == ADDR_DATA ? wdata :
                  address == ADDR_SET  ? data_q | wdata :
                  address == ADDR_CLR  ? data_q & ~wdata : data_q;
        mask_d  = wr && address == ADDR_MASK ? wdata : mask_q;
        cap_d   = (cap_q & ~(wr && address == ADDR_EDGE ? wdata : '0)) | edge_evt;
        irq_d   = IRQ_MODE == IRQ_LEVEL ? |(in_sync & mask_q) : |(cap_q & mask_q);
        rdata_d = address == ADDR_DATA ? 32'(in_sync) :
                  address == ADDR_MASK ? 32'(mask_q) :
                  address == ADDR_EDGE ? 32'(cap_q) : 32'd0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q  <= RESET_VALUE;
            mask_q  <= '0;
            cap_q   <= '0;
            irq_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            data_q  <= data_d;
            mask_q  <= mask_d;
            cap_q   <= cap_d;
            irq_q   <= irq_d;
            rdata_q <= rdata_d;
        end
    end

    assign out_port = data_q;
    assign readdata = rdata_q;
    assign irq      = irq_q;
endmodule

// File: tb/tb_soc_system_pio_gen.sv
// tb_soc_system_pio_gen: three differently parametrised PIOs on one shared bus,
// checked against a queue-based reference model through a scoreboard
module tb_soc_system_pio_gen;
    localparam int          W  [3] = '{16, 32, 8};
    localparam int          S  [3] = '{2, 3, 4};
    localparam int          ET [3] = '{0, 2, 1};
    localparam int          IM [3] = '{1, 0, 1};
    localparam logic [31:0] RV [3] = '{32'h0000A5A5, 32'hDEADBEEF, 32'h0000003C};

    typedef struct packed {
        logic [2:0][31:0] rd;
        logic [2:0][31:0] out;
        logic [2:0]       irq;
    } exp_t;

    logic        clk, reset, chipselect, write_n;
    logic [2:0]  address;
    logic [31:0] writedata, in32;
    logic [31:0] rd0, rd1, rd2;
    logic [15:0] out0;
    logic [31:0] out1;
    logic [7:0]  out2;
    logic        irq0, irq1, irq2;
    logic [2:0][31:0] d_rd, d_out;
    logic [2:0]       d_irq;

    exp_t        sb [$];
    logic [31:0] m_data [3], m_mask [3], m_cap [3], m_rd [3];
    logic        m_irq [3];
    logic [31:0] hist [3][6];
    int          n_vec = 0, n_err = 0;

    soc_system_pio_gen #(.WIDTH(16), .RESET_VALUE(16'hA5A5), .SYNC_STAGES(2), .EDGE_TYPE(0), .IRQ_MODE(1)) u0 (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
        .writedata(writedata), .readdata(rd0), .in_port(in32[15:0]), .out_port(out0), .irq(irq0));
    soc_system_pio_gen #(.WIDTH(32), .RESET_VALUE(32'hDEADBEEF), .SYNC_STAGES(3), .EDGE_TYPE(2), .IRQ_MODE(0)) u1 (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
        .writedata(writedata), .readdata(rd1), .in_port(in32), .out_port(out1), .irq(irq1));
    soc_system_pio_gen #(.WIDTH(8), .RESET_VALUE(8'h3C), .SYNC_STAGES(4), .EDGE_TYPE(1), .IRQ_MODE(1)) u2 (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
        .writedata(writedata), .readdata(rd2), .in_port(in32[7:0]), .out_port(out2), .irq(irq2));

    assign d_rd  = {rd2, rd1, rd0};
    assign d_out = {{24'h0, out2}, out1, {16'h0, out0}};
    assign d_irq = {irq2, irq1, irq0};

    initial begin
        clk = 0;
        #20;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] wm(input int k);
        return W[k] == 32 ? 32'hFFFFFFFF : (32'd1 << W[k]) - 32'd1;
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < 3; k++) begin
            m_data[k] = RV[k];
            m_mask[k] = 0;
            m_cap[k]  = 0;
            m_rd[k]   = 0;
            m_irq[k]  = 0;
            for (int d = 0; d < 6; d++) hist[k][d] = 0;
        end
    endfunction

    // hist[k][d] is the in_port value sampled d edges ago, so in_sync is hist[S] and prev is hist[S+1]
    task automatic model_step(input logic rst, input logic cs, input logic wn, input logic [2:0] a,
                              input logic [31:0] wd, input logic [31:0] inp);
        exp_t        e;
        logic [31:0] m, wv, isync, prv, ev, nd;
        logic        wr;
        if (rst) model_reset();
        else for (int k = 0; k < 3; k++) begin
            m     = wm(k);
            wv    = wd & m;
            wr    = cs && !wn;
            isync = hist[k][S[k]];
            prv   = hist[k][S[k]+1];
            ev    = ET[k] == 0 ? isync & ~prv : ET[k] == 1 ? ~isync & prv : isync ^ prv;
            nd    = m_data[k];
            if (wr) case (a)
                3'd0: nd = wv;
                3'd4: nd = m_data[k] | wv;
                3'd5: nd = m_data[k] & ~wv;
                default: ;
            endcase
            m_irq[k]  = IM[k] == 0 ? |(isync & m_mask[k]) : |(m_cap[k] & m_mask[k]);
            m_rd[k]   = a == 3'd0 ? isync : a == 3'd2 ? m_mask[k] : a == 3'd3 ? m_cap[k] : 32'd0;
            m_cap[k]  = (m_cap[k] & ~((wr && a == 3'd3) ? wv : 32'd0)) | ev;
            m_mask[k] = (wr && a == 3'd2) ? wv : m_mask[k];
            m_data[k] = nd;
            for (int d = 5; d > 1; d--) hist[k][d] = hist[k][d-1];
            hist[k][1] = inp & m;
        end
        for (int k = 0; k < 3; k++) begin
            e.rd[k]  = m_rd[k];
            e.out[k] = m_data[k];
            e.irq[k] = m_irq[k];
        end
        sb.push_back(e);
    endtask

    task automatic step(input logic rst, input logic cs, input logic wn, input logic [2:0] a,
                        input logic [31:0] wd, input logic [31:0] inp);
        reset = rst;
        chipselect = cs;
        write_n = wn;
        address = a;
        writedata = wd;
        in32 = inp;
        model_step(rst, cs, wn, a, wd, inp);
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n, input logic [2:0] a, input logic [31:0] inp);
        for (int i = 0; i < n; i++) step(0, 0, 1, a, $urandom, inp);
    endtask

    task automatic chk_reset_state(input string tag);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("%s_out%0d", tag, k), d_out[k], RV[k]);
            chk($sformatf("%s_rd%0d", tag, k), d_rd[k], 32'd0);
            chk($sformatf("%s_irq%0d", tag, k), {31'd0, d_irq[k]}, 32'd0);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                for (int k = 0; k < 3; k++) begin
                    chk($sformatf("sb_rd%0d", k), d_rd[k], e.rd[k]);
                    chk($sformatf("sb_out%0d", k), d_out[k], e.out[k]);
                    chk($sformatf("sb_irq%0d", k), {31'd0, d_irq[k]}, {31'd0, e.irq[k]});
                end
            end
        end
    end

    initial begin
        logic [31:0] inp;
        reset = 0;
        chipselect = 0;
        write_n = 1;
        address = 0;
        writedata = 0;
        in32 = 0;
        #3 reset = 1;
        #1 chk_reset_state("rst_noclk");
        model_reset();
        @(posedge clk);
        #2;
        step(1, 0, 1, 0, 0, 0);
        step(1, 0, 1, 0, 0, 0);
        idle(2, 0, 0);
        // output register: load, set, clear
        step(0, 1, 0, 0, 32'hFFFF1234, 0);
        chk("data_w16", d_out[0], 32'h00001234);
        chk("data_w32", d_out[1], 32'hFFFF1234);
        step(0, 1, 0, 4, 32'h000000F0, 0);
        chk("set_w16", d_out[0], 32'h000012F4);
        chk("set_w32", d_out[1], 32'hFFFF12F4);
        step(0, 1, 0, 5, 32'h00000204, 0);
        chk("clr_w16", d_out[0], 32'h000010F0);
        chk("clr_w32", d_out[1], 32'hFFFF10F0);
        // DATA read is in_sync, zero-extended
        idle(6, 0, 32'hFFFFFFFF);
        chk("rd_data_w16", d_rd[0], 32'h0000FFFF);
        chk("rd_data_w32", d_rd[1], 32'hFFFFFFFF);
        idle(7, 0, 0);
        step(0, 1, 0, 3, 32'hFFFFFFFF, 0);
        idle(1, 0, 0);
        // rising capture and edge irq timing on the SYNC_STAGES=2 instance
        step(0, 1, 0, 2, 32'h1, 0);
        idle(3, 3, 32'h1);
        chk("cap_early", d_rd[0], 32'h0);
        chk("irq_early", {31'd0, d_irq[0]}, 32'd0);
        idle(1, 3, 32'h1);
        chk("cap_set", d_rd[0], 32'h1);
        chk("irq_set", {31'd0, d_irq[0]}, 32'd1);
        step(0, 1, 0, 3, 32'h1, 32'h1);
        chk("irq_hold", {31'd0, d_irq[0]}, 32'd1);
        idle(1, 3, 32'h1);
        chk("irq_drop", {31'd0, d_irq[0]}, 32'd0);
        // clear arriving with a new event: event wins
        idle(5, 3, 0);
        idle(2, 3, 32'h1);
        step(0, 1, 0, 3, 32'h1, 32'h1);
        idle(1, 3, 32'h1);
        chk("cap_wins", d_rd[0], 32'h1);
        // level irq on the 32-bit instance
        step(0, 1, 0, 2, 32'h8, 32'h1);
        idle(1, 0, 32'h1);
        idle(3, 0, 32'h9);
        chk("lvl_early", {31'd0, d_irq[1]}, 32'd0);
        idle(1, 0, 32'h9);
        chk("lvl_set", {31'd0, d_irq[1]}, 32'd1);
        idle(3, 0, 32'h1);
        chk("lvl_hold", {31'd0, d_irq[1]}, 32'd1);
        idle(1, 0, 32'h1);
        chk("lvl_drop", {31'd0, d_irq[1]}, 32'd0);
        step(0, 1, 0, 2, 32'h0, 32'h9);
        idle(5, 0, 32'h9);
        chk("lvl_masked", {31'd0, d_irq[1]}, 32'd0);
        // unmapped offsets
        step(0, 1, 0, 6, 32'hFFFFFFFF, 32'h9);
        step(0, 1, 1, 1, 0, 32'h9);
        step(0, 1, 1, 6, 0, 32'h9);
        step(0, 1, 1, 7, 0, 32'h9);
        chk("rd_addr7", d_rd[1], 32'h0);
        // randomised traffic
        inp = $urandom;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) inp = $urandom;
            step($urandom_range(0, 99) == 0, 1'($urandom), 1'($urandom), 3'($urandom), $urandom, inp);
        end
        // asynchronous reset in the middle of a write burst
        step(0, 1, 0, 2, 32'hFFFFFFFF, inp);
        step(0, 1, 0, 4, 32'h0F0F0F0F, inp);
        chipselect = 1;
        write_n = 0;
        address = 0;
        writedata = 32'h12345678;
        #3 reset = 1;
        #1 chk_reset_state("rst_mid");
        sb.delete();
        model_reset();
        step(1, 1, 0, 0, 32'h12345678, inp);
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 3) == 0) inp = $urandom;
            step(0, 1'($urandom), 1'($urandom), 3'($urandom), $urandom, inp);
        end
        idle(2, 0, inp);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
